// File: rtl/kf8237_dma_peripheral_endpoint.sv
// Peripheral-side DMA endpoint for a KF8237 channel: raises DREQ, answers DACK/IOR/IOW
// bus cycles and buffers bytes between the local device port and the bus in one FIFO.
module kf8237_dma_peripheral_endpoint #(
    parameter int FIFO_DEPTH        = 16,
    parameter int REQUEST_THRESHOLD = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         direction,
    input  logic                         demand_mode,
    output logic                         dma_request,
    input  logic                         dma_acknowledge,
    input  logic                         io_read_n,
    input  logic                         io_write_n,
    input  logic                         terminal_count,
    input  logic [7:0]                   data_bus_in,
    output logic [7:0]                   data_bus_out,
    output logic                         data_bus_io,
    input  logic                         local_write,
    input  logic [7:0]                   local_write_data,
    input  logic                         local_read,
    output logic [7:0]                   local_read_data,
    output logic                         local_full,
    output logic                         local_empty,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         transfer_done,
    output logic                         overrun,
    input  logic                         clear_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] THRESH_L = LW'(REQUEST_THRESHOLD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQUEST,
        S_ACKED,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            dir_q;
    logic            demand_q;
    logic            tc_seen;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    logic [LW-1:0]   level_next;
    logic [7:0]      bus_byte;
    logic [7:0]      head;
    logic            strobe_low;
    logic            bus_hit;
    logic            complete;
    logic            abort;
    logic            push_req;
    logic            pop_req;
    logic            push_ok;
    logic            pop_ok;
    logic            full;
    logic            empty;
    logic            ready;
    logic            ready_after;

    function automatic logic is_ready(input logic dir, input logic [LW-1:0] lvl);
        if (dir)
            return (DEPTH_L - lvl) >= THRESH_L;
        else
            return lvl >= THRESH_L;
    endfunction

    assign strobe_low = dir_q ? ~io_write_n : ~io_read_n;
    assign bus_hit    = dma_acknowledge & strobe_low;
    assign complete   = (state == S_ACKED) & dma_acknowledge & ~strobe_low;
    // Losing DACK before the strobe finishes is an abort, never a completed byte.
    assign abort      = (state == S_ACKED) & ~dma_acknowledge;

    assign full      = (level == DEPTH_L);
    assign empty     = (level == '0);
    assign head      = mem[rd_ptr];
    assign push_req  = dir_q ? complete : local_write;
    assign pop_req   = dir_q ? local_read : complete;
    assign pop_ok    = pop_req & ~empty;
    assign push_ok   = push_req & (~full | pop_ok);

    always_comb begin
        level_next = level;
        if (push_ok && !pop_ok)
            level_next = level + 1'b1;
        else if (pop_ok && !push_ok)
            level_next = level - 1'b1;
    end

    assign ready       = is_ready(dir_q, level);
    assign ready_after = is_ready(dir_q, level_next);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level_next;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok)
            mem[wr_ptr] <= dir_q ? bus_byte : local_write_data;
        if (dir_q && strobe_low)
            bus_byte <= data_bus_in;
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // An acknowledged strobe arriving in IDLE is a cycle the controller committed to
    // before DREQ dropped; it is served so a push into a full FIFO is seen as overrun.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (bus_hit)
                    next_state = S_ACKED;
                else if (enable && ready && !transfer_done)
                    next_state = S_REQUEST;
            end
            S_REQUEST: begin
                if (bus_hit)
                    next_state = S_ACKED;
                else if (!enable)
                    next_state = S_IDLE;
            end
            S_ACKED: begin
                if (abort)
                    next_state = S_REQUEST;
                else if (complete) begin
                    if (tc_seen)
                        next_state = S_DONE;
                    else if (!demand_q)
                        next_state = S_RELEASE;
                    else if (enable && ready_after)
                        next_state = S_REQUEST;
                    else
                        next_state = S_IDLE;
                end
            end
            S_RELEASE: next_state = S_IDLE;
            S_DONE: begin
                if (clear_done)
                    next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dir_q         <= 1'b0;
            demand_q      <= 1'b0;
            tc_seen       <= 1'b0;
            transfer_done <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (state == S_IDLE || state == S_DONE) begin
                dir_q    <= direction;
                demand_q <= demand_mode;
            end
            if (complete || abort)
                tc_seen <= 1'b0;
            else if (bus_hit && terminal_count && (state == S_ACKED || next_state == S_ACKED))
                tc_seen <= 1'b1;
            if (clear_done)
                transfer_done <= 1'b0;
            else if (complete && tc_seen)
                transfer_done <= 1'b1;
            if (clear_done)
                overrun <= 1'b0;
            else if (dir_q && complete && full && !pop_ok)
                overrun <= 1'b1;
        end
    end

    always_comb begin
        dma_request = 1'b0;
        case (state)
            S_REQUEST: dma_request = 1'b1;
            S_ACKED:   dma_request = demand_q;
            default:   dma_request = 1'b0;
        endcase
    end

    assign data_bus_io     = (state == S_ACKED) & ~dir_q & dma_acknowledge & ~io_read_n;
    assign data_bus_out    = ((state == S_ACKED) && !dir_q && !empty) ? head : 8'h00;
    assign local_read_data = empty ? 8'h00 : head;
    assign local_full      = full;
    assign local_empty     = empty;
    assign fifo_level      = level;

endmodule

// File: tb/tb_kf8237_dma_peripheral_endpoint.sv
// Directed bench for the KF8237 peripheral endpoint; a queue models the FIFO contents
// and is checked whenever a byte leaves the DUT on the bus or the local port.
module tb_kf8237_dma_peripheral_endpoint;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          direction;
    logic          demand_mode;
    logic          dma_request;
    logic          dma_acknowledge;
    logic          io_read_n;
    logic          io_write_n;
    logic          terminal_count;
    logic [7:0]    data_bus_in;
    logic [7:0]    data_bus_out;
    logic          data_bus_io;
    logic          local_write;
    logic [7:0]    local_write_data;
    logic          local_read;
    logic [7:0]    local_read_data;
    logic          local_full;
    logic          local_empty;
    logic [LW-1:0] fifo_level;
    logic          transfer_done;
    logic          overrun;
    logic          clear_done;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb[$];

    kf8237_dma_peripheral_endpoint #(
        .FIFO_DEPTH(DEPTH),
        .REQUEST_THRESHOLD(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .direction(direction),
        .demand_mode(demand_mode),
        .dma_request(dma_request),
        .dma_acknowledge(dma_acknowledge),
        .io_read_n(io_read_n),
        .io_write_n(io_write_n),
        .terminal_count(terminal_count),
        .data_bus_in(data_bus_in),
        .data_bus_out(data_bus_out),
        .data_bus_io(data_bus_io),
        .local_write(local_write),
        .local_write_data(local_write_data),
        .local_read(local_read),
        .local_read_data(local_read_data),
        .local_full(local_full),
        .local_empty(local_empty),
        .fifo_level(fifo_level),
        .transfer_done(transfer_done),
        .overrun(overrun),
        .clear_done(clear_done)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic lw(input logic [7:0] d);
        local_write      = 1'b1;
        local_write_data = d;
        tick();
        local_write = 1'b0;
        if (!direction && sb.size() < DEPTH)
            sb.push_back(d);
    endtask

    task automatic lr(input string tag);
        logic [7:0] e;
        e = 8'h00;
        if (sb.size() > 0)
            e = sb.pop_front();
        chk(tag, local_read_data, e);
        local_read = 1'b1;
        tick();
        local_read = 1'b0;
    endtask

    task automatic bus_read(input int clks, input logic dreq_acked, input logic dreq_after,
                            input string tag);
        logic [7:0] e;
        dma_acknowledge = 1'b1;
        io_read_n       = 1'b0;
        repeat (clks) tick();
        e = 8'h00;
        if (sb.size() > 0)
            e = sb[0];
        chk({tag, "_io"}, data_bus_io, 1);
        chk({tag, "_data"}, data_bus_out, e);
        chk({tag, "_dreq_acked"}, dma_request, dreq_acked);
        io_read_n = 1'b1;
        tick();
        if (sb.size() > 0)
            void'(sb.pop_front());
        chk({tag, "_level"}, fifo_level, sb.size());
        chk({tag, "_dreq_after"}, dma_request, dreq_after);
        dma_acknowledge = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] d, input logic tc, input int clks,
                             input logic dreq_after, input string tag);
        dma_acknowledge = 1'b1;
        io_write_n      = 1'b0;
        data_bus_in     = d;
        terminal_count  = tc;
        repeat (clks) tick();
        io_write_n     = 1'b1;
        terminal_count = 1'b0;
        tick();
        if (sb.size() < DEPTH)
            sb.push_back(d);
        chk({tag, "_level"}, fifo_level, sb.size());
        chk({tag, "_dreq_after"}, dma_request, dreq_after);
        dma_acknowledge = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; direction = 1'b0; demand_mode = 1'b0;
        dma_acknowledge = 1'b0; io_read_n = 1'b1; io_write_n = 1'b1; terminal_count = 1'b0;
        data_bus_in = 8'h00; local_write = 1'b0; local_write_data = 8'h00;
        local_read = 1'b0; clear_done = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_dreq", dma_request, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_empty", local_empty, 1);
        chk("rst_full", local_full, 0);
        chk("rst_bus_out", data_bus_out, 0);
        chk("rst_bus_io", data_bus_io, 0);
        chk("rst_rdata", local_read_data, 0);
        chk("rst_done", transfer_done, 0);
        chk("rst_overrun", overrun, 0);

        // single mode, device to memory
        enable = 1'b1;
        tick();
        lw(8'hA5);
        chk("t1_dreq_same_clk", dma_request, 0);
        tick();
        chk("t1_dreq_rise", dma_request, 1);
        bus_read(3, 1'b0, 1'b0, "t1_read");
        tick();
        chk("t1_gap", dma_request, 0);
        tick();
        chk("t1_idle", dma_request, 0);

        // demand mode burst of four bytes
        demand_mode = 1'b1;
        for (int i = 0; i < 4; i++)
            lw(8'h10 + 8'(i));
        chk("t2_dreq", dma_request, 1);
        for (int i = 0; i < 4; i++)
            bus_read(2, 1'b1, (i < 3), $sformatf("t2_rd%0d", i));

        // memory to device, TC on third byte
        direction = 1'b1;
        tick(); tick();
        chk("t3_dreq", dma_request, 1);
        bus_write(8'h31, 1'b0, 2, 1'b1, "t3_w0");
        bus_write(8'h52, 1'b0, 2, 1'b1, "t3_w1");
        bus_write(8'h7E, 1'b1, 2, 1'b0, "t3_w2");
        chk("t3_done", transfer_done, 1);
        tick(); tick();
        chk("t3_dreq_held_low", dma_request, 0);
        chk("t3_done_sticky", transfer_done, 1);
        clear_done = 1'b1;
        tick();
        clear_done = 1'b0;
        chk("t3_done_clr", transfer_done, 0);
        chk("t3_dreq_clr", dma_request, 0);
        tick();
        chk("t3_dreq_reassert", dma_request, 1);
        enable = 1'b0;
        tick();
        for (int i = 0; i < 3; i++)
            lr($sformatf("t3_drain%0d", i));
        chk("t3_empty", local_empty, 1);

        // fill to full, then one extra acknowledged write overruns
        enable = 1'b1;
        tick();
        for (int i = 0; i < DEPTH - 1; i++)
            bus_write(8'h40 + 8'(i), 1'b0, 1, 1'b1, $sformatf("t4_w%0d", i));
        bus_write(8'h5F, 1'b0, 1, 1'b0, "t4_w15");
        chk("t4_full", local_full, 1);
        chk("t4_no_overrun_yet", overrun, 0);
        bus_write(8'hFF, 1'b0, 1, 1'b0, "t4_w16");
        chk("t4_overrun", overrun, 1);
        chk("t4_level16", fifo_level, DEPTH);
        enable = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            lr($sformatf("t4_drain%0d", i));
        chk("t4_empty", local_empty, 1);
        clear_done = 1'b1;
        tick();
        clear_done = 1'b0;
        chk("t4_overrun_clr", overrun, 0);

        // abort: DACK falls mid-IOR with TC asserted
        direction   = 1'b0;
        demand_mode = 1'b0;
        tick();
        enable = 1'b1;
        lw(8'h81);
        lw(8'h82);
        chk("t5_dreq", dma_request, 1);
        dma_acknowledge = 1'b1; io_read_n = 1'b0; terminal_count = 1'b1;
        tick(); tick();
        chk("t5_io", data_bus_io, 1);
        dma_acknowledge = 1'b0;
        tick();
        chk("t5_level", fifo_level, 2);
        chk("t5_back_to_request", dma_request, 1);
        io_read_n = 1'b1; terminal_count = 1'b0;
        tick();
        chk("t5_dreq_hold", dma_request, 1);
        bus_read(2, 1'b0, 1'b0, "t5_read");
        chk("t5_no_tc", transfer_done, 0);
        tick(); tick();
        chk("t5_rerequest", dma_request, 1);

        // unacknowledged strobe and wrong-direction local write
        io_read_n = 1'b0;
        tick(); tick();
        chk("t6_io_nodack", data_bus_io, 0);
        io_read_n = 1'b1;
        tick();
        chk("t6_level_nodack", fifo_level, 1);
        enable = 1'b0;
        tick();
        direction = 1'b1;
        tick();
        lw(8'hEE);
        chk("t6_level_wrongdir", fifo_level, 1);

        // reset while a bus read is in progress
        direction = 1'b0;
        enable    = 1'b1;
        tick(); tick();
        dma_acknowledge = 1'b1; io_read_n = 1'b0;
        tick();
        chk("t7_io", data_bus_io, 1);
        chk("t7_data", data_bus_out, sb[0]);
        reset = 1'b1;
        tick();
        sb.delete();
        chk("t7_dreq", dma_request, 0);
        chk("t7_io_off", data_bus_io, 0);
        chk("t7_bus_out", data_bus_out, 0);
        chk("t7_level", fifo_level, 0);
        chk("t7_empty", local_empty, 1);
        chk("t7_rdata", local_read_data, 0);
        chk("t7_done", transfer_done, 0);
        chk("t7_overrun", overrun, 0);
        reset = 1'b0; dma_acknowledge = 1'b0; io_read_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kf8237_dma_peripheral_endpoint.md
Name: kf8237_dma_peripheral_endpoint

Overview:
- Peripheral-side counterpart of the KF8237 DMA channel. It raises DREQ, answers DACK with IOR/IOW strobes, and observes TC.
- Buffers bytes between a local device port and the DMA bus cycle through a single byte FIFO.
- Direction is selectable per transfer:
  - device→memory: the 8237 "write" transfer; the endpoint drives data during IOR.
  - memory→device: the 8237 "read" transfer; the endpoint captures data during IOW.
- Sits between a peripheral core (e.g. floppy/HDD data path) and the PC-XT bus glue.

Parameters:
- FIFO_DEPTH, 16, FIFO entries (power of 2, ≥2).
- REQUEST_THRESHOLD, 1, bytes available (dir 0) or free slots (dir 1) required before DREQ is raised (1..FIFO_DEPTH).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  arms the endpoint
- direction  in  1  0 = device→memory, 1 = memory→device
- demand_mode  in  1  0 = single-byte requests, 1 = hold DREQ while ready
- dma_request  out  1  DREQ to controller
- dma_acknowledge  in  1  DACK, active high
- io_read_n  in  1  bus IOR strobe, active low
- io_write_n  in  1  bus IOW strobe, active low
- terminal_count  in  1  TC from controller
- data_bus_in  in  8  bus data captured in dir 1
- data_bus_out  out  8  bus data driven in dir 0
- data_bus_io  out  1  1 = endpoint drives data_bus_out
- local_write  in  1  push strobe (dir 0 only)
- local_write_data  in  8  push data
- local_read  in  1  pop strobe (dir 1 only)
- local_read_data  out  8  FIFO head
- local_full  out  1  FIFO full
- local_empty  out  1  FIFO empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy
- transfer_done  out  1  sticky, set by TC completion
- overrun  out  1  sticky, bus push attempted while full
- clear_done  in  1  clears transfer_done and overrun

Behaviour:
- Reset:
  - state IDLE, FIFO empty, fifo_level 0, local_empty 1.
  - All other outputs 0, including data_bus_out and local_read_data.
- FIFO:
  - Circular buffer; pointers wrap at FIFO_DEPTH.
  - Push while full is dropped. Pop while empty is ignored and level is unchanged.
  - Simultaneous push and pop leaves the level unchanged and the head advances.
  - local_write is ignored when direction=1; local_read is ignored when direction=0.
- ready:
  - dir 0: fifo_level ≥ REQUEST_THRESHOLD.
  - dir 1: (FIFO_DEPTH − fifo_level) ≥ REQUEST_THRESHOLD.
- active_strobe: ~io_read_n in dir 0, ~io_write_n in dir 1. A strobe without dma_acknowledge is ignored.
- IDLE:
  - dma_request=0.
  - enable & ready & ~transfer_done → REQUEST. dma_request is registered, so it rises one clock after ready.
- REQUEST:
  - dma_request=1.
  - dma_acknowledge & active_strobe → ACKED.
  - ~enable → IDLE.
- ACKED:
  - Single mode: dma_request=0. Demand mode: dma_request=1.
  - dir 0: data_bus_io=1 while dma_acknowledge & ~io_read_n; data_bus_out = FIFO head.
  - dir 1: data_bus_in is registered on every clock the strobe is low.
  - terminal_count sampled high on any strobe-low clock sets internal tc_seen.
- Strobe completion (strobe returns high while dma_acknowledge=1):
  - Exactly one FIFO pop (dir 0), or one push of the last registered byte (dir 1).
  - Push into a full FIFO sets overrun.
  - Next state:
    - tc_seen → DONE.
    - else single mode → RELEASE.
    - else demand mode → REQUEST if enable & ready (evaluated after this transfer), otherwise IDLE.
- Abort: dma_acknowledge falls while the strobe is still low → no FIFO change, tc_seen cleared, back to REQUEST. enable is ignored until the strobe completes.
- RELEASE: dma_request=0 for exactly one clock, then IDLE. This guarantees a DREQ low gap between single transfers.
- DONE:
  - dma_request=0, transfer_done=1.
  - Only clear_done exits (→ IDLE); enable has no effect.
  - clear_done clears transfer_done and overrun in any state.
- Direction or demand_mode changes take effect only in IDLE/DONE. Software must not change them mid-transfer.
- Reset mid-ACKED: immediate IDLE, FIFO flushed, data_bus_io=0 on the next clock.

Test Plan:
- Single mode dir 0, threshold 1: push 0xA5 → dma_request high one clock later. DACK + 3-clock IOR → data_bus_out=0xA5 and data_bus_io=1 during IOR. At IOR rise: level 0; DREQ low ≥1 clock; stays IDLE.
- Demand mode dir 0, push 0x10..0x13: four back-to-back DACK/IOR cycles with DREQ held high throughout → bus reads 0x10,0x11,0x12,0x13. After the last byte: level 0, DREQ low.
- Dir 1, TC on the third IOW carrying 0x7E → FIFO holds 3 bytes, last = 0x7E. State DONE, transfer_done=1, DREQ stays 0 despite free space. clear_done → DREQ reasserts one clock later.
- Dir 1, FIFO_DEPTH=16, threshold 1: fill to 15, demand cycle pushes 2 bytes → 16th accepted, 17th dropped, overrun=1, level 16, DREQ 0.
- Abort: DACK drops mid-IOR in dir 0 with level 2 → level stays 2, returns to REQUEST, no TC recorded.
- IOR pulse with dma_acknowledge=0, and local_write while direction=1 → no FIFO change. Reset asserted mid-ACKED → all outputs 0 on the next clock.
